spi_tx_queue: RTL and testbench
===============================

Name: spi_tx_queue

Overview:
- Byte FIFO and issue controller sitting directly upstream of the SPI master.
- Accepts bursts of bytes from user logic (e.g. debounced-button character generators) and replays them one at a time into the master's TX handshake (i_TX_Byte / i_TX_DV / o_TX_Ready).
- Also monitors the master's RX pulse to report the last received byte and running transfer counts, so the top level can drive the 7-segment display without its own handshake logic.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..256.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst_L  in  1  synchronous active-low reset, sampled on rising edge of i_Clk.
- i_Wr_DV  in  1  one-cycle write strobe from user logic.
- i_Wr_Byte  in  8  byte to enqueue; sampled when i_Wr_DV=1.
- i_Flush  in  1  empties the FIFO and clears o_Overflow.
- o_Full  out  1  FIFO holds DEPTH entries.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Count  out  CW  current occupancy.
- o_Overflow  out  1  sticky: a write was dropped.
- o_TX_Byte  out  8  to master i_TX_Byte.
- o_TX_DV  out  1  to master i_TX_DV; one-cycle pulse.
- i_TX_Ready  in  1  from master o_TX_Ready.
- i_RX_DV  in  1  from master o_RX_DV.
- i_RX_Byte  in  8  from master o_RX_Byte.
- o_Last_RX  out  8  most recent byte received.
- o_Sent_Cnt  out  8  bytes issued to the master; wraps 255->0.
- o_Busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (i_Rst_L=0 at edge):
  - FIFO pointers=0, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0.
  - o_TX_DV=0, o_TX_Byte=8'h00, o_Last_RX=8'h00, o_Sent_Cnt=0.
  - FSM=IDLE, o_Busy=0.
  - Reset mid-transfer abandons queued bytes; the master finishes any byte already issued on its own.
- All outputs are registered. Full, empty and count decisions use the state at the start of the cycle.
- Write:
  - i_Wr_DV=1 and !o_Full: byte stored at the write pointer, pointer wraps modulo DEPTH.
  - i_Wr_DV=1 and o_Full: byte dropped, o_Overflow<=1. This holds even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if !o_Empty and i_TX_Ready=1, then o_TX_Byte<=head byte, o_TX_DV<=1, pop, o_Sent_Cnt<=o_Sent_Cnt+1, go to ISSUE.
  - ISSUE: o_TX_DV<=0; i_TX_Ready is ignored in this cycle (the master drops Ready one edge after DV); go to WAIT.
  - WAIT: stay until i_TX_Ready=1, then go to IDLE.
- Transfer spacing:
  - Consecutive DV pulses are at least 3 cycles apart.
  - o_TX_Byte holds its value until the next issue.
- Latency: a write at cycle t into an empty queue, with FSM in IDLE and Ready=1, produces o_TX_DV=1 at cycle t+1 carrying that byte.
- Simultaneous write and pop in one cycle: o_Count is unchanged. Both proceed when !o_Full and !o_Empty.
- Flush:
  - Pointers and count go to 0, o_Overflow goes to 0.
  - Flush has priority over a same-cycle write (the write is dropped and does not set overflow) and over a same-cycle pop (no DV is issued).
  - FSM states ISSUE/WAIT continue to completion.
  - o_Sent_Cnt and o_Last_RX are unaffected.
- RX: on i_RX_DV=1, o_Last_RX<=i_RX_Byte. RX capture is independent of the FSM and flush.
- o_Busy = (FSM!=IDLE) | !o_Empty, registered from the next-state values.

Test Plan:
- Reset, then write 8'h61 at t with i_TX_Ready=1 -> o_TX_DV=1 and o_TX_Byte=8'h61 at t+1; o_Sent_Cnt=1; o_Empty=1 at t+1.
- Write 'a'..'e' (8'h61..8'h65) back-to-back; master model drops Ready for 20 cycles after each DV -> DV pulses carry 61..65 in order, ≥22 cycles apart, o_Busy falls only after the last Ready returns.
- With Ready held 0, write 9 bytes (DEPTH=8) -> o_Full=1, o_Count=8, o_Overflow=1; the 9th byte is never issued.
- Full queue, Ready held 0, assert i_Wr_DV and i_Flush together -> o_Count=0, o_Empty=1, o_Overflow=0, no DV afterwards.
- Drive i_RX_DV with 8'hA5 then 8'h3C while a transfer is in WAIT -> o_Last_RX=8'hA5, then 8'h3C, one cycle after each pulse.
- Issue 256 bytes -> o_Sent_Cnt wraps to 0; assert i_Rst_L=0 during WAIT -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/spi_tx_queue_if.sv
// rtl/spi_tx_queue_if.sv - handshake bundle between user logic, the issue queue and the SPI master
interface spi_tx_queue_if #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic          i_Wr_DV;
  logic [7:0]    i_Wr_Byte;
  logic          i_Flush;
  logic          o_Full;
  logic          o_Empty;
  logic [CW-1:0] o_Count;
  logic          o_Overflow;
  logic [7:0]    o_TX_Byte;
  logic          o_TX_DV;
  logic          i_TX_Ready;
  logic          i_RX_DV;
  logic [7:0]    i_RX_Byte;
  logic [7:0]    o_Last_RX;
  logic [7:0]    o_Sent_Cnt;
  logic          o_Busy;

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Flush, i_TX_Ready, i_RX_DV, i_RX_Byte,
    output o_Full, o_Empty, o_Count, o_Overflow, o_TX_Byte, o_TX_DV,
           o_Last_RX, o_Sent_Cnt, o_Busy
  );

  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Flush, i_TX_Ready, i_RX_DV, i_RX_Byte,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_Byte, o_TX_DV,
           o_Last_RX, o_Sent_Cnt, o_Busy
  );
endinterface

// File: rtl/spi_tx_queue.sv
// rtl/spi_tx_queue.sv - byte FIFO replaying queued bytes into the SPI master TX handshake
// Also tracks the last RX byte and a wrapping count of bytes issued.
module spi_tx_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  spi_tx_queue_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [7:0]    last_rx_q, last_rx_d;
  logic [7:0]    sent_q, sent_d;
  logic          busy_q, busy_d;
  logic          wr_en;
  logic          pop;

  // Flush wins over both a same-cycle write and a same-cycle issue.
  always_comb begin
    wr_en = bus.i_Wr_DV && !full_q && !bus.i_Flush;
    pop   = (state_q == S_IDLE) && !empty_q && bus.i_TX_Ready && !bus.i_Flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (bus.i_Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (bus.i_Wr_DV && full_q) ovf_d = 1'b1;
      case ({wr_en, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    sent_d    = sent_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_byte_d = mem_q[rd_ptr_q];
          tx_dv_d   = 1'b1;
          sent_d    = sent_q + 8'd1;
          state_d   = S_ISSUE;
        end
      end
      // The master only drops Ready one edge after DV, so Ready is stale here.
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_TX_Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    last_rx_d = bus.i_RX_DV ? bus.i_RX_Byte : last_rx_q;
    busy_d    = (state_d != S_IDLE) || !empty_d;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      last_rx_q <= 8'h00;
      sent_q    <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      last_rx_q <= last_rx_d;
      sent_q    <= sent_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst_L && wr_en) mem_q[wr_ptr_q] <= bus.i_Wr_Byte;
  end

  assign bus.o_Full     = full_q;
  assign bus.o_Empty    = empty_q;
  assign bus.o_Count    = count_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_TX_DV    = tx_dv_q;
  assign bus.o_TX_Byte  = tx_byte_q;
  assign bus.o_Last_RX  = last_rx_q;
  assign bus.o_Sent_Cnt = sent_q;
  assign bus.o_Busy     = busy_q;

endmodule

// File: tb/tb_spi_tx_queue.sv
// tb/tb_spi_tx_queue.sv - directed self-checking bench for spi_tx_queue
module tb_spi_tx_queue;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_l;
  int   tests_run    = 0;
  int   tests_failed = 0;

  spi_tx_queue_if #(.DEPTH(DEPTH), .CW(CW)) bus ();
  spi_tx_queue #(.DEPTH(DEPTH), .CW(CW)) dut (.i_Clk(clk), .i_Rst_L(rst_l), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs;
    bus.i_Wr_DV   = 1'b0;
    bus.i_Wr_Byte = 8'h00;
    bus.i_Flush   = 1'b0;
    bus.i_RX_DV   = 1'b0;
    bus.i_RX_Byte = 8'h00;
  endtask

  task automatic test_reset;
    logic [8:0]  flags;
    logic [23:0] data;
    rst_l = 1'b0;
    idle_inputs();
    bus.i_TX_Ready = 1'b1;
    repeat (3) @(negedge clk);
    flags = {bus.o_Empty, bus.o_Full, bus.o_Count, bus.o_Overflow, bus.o_TX_DV, bus.o_Busy};
    data  = {bus.o_TX_Byte, bus.o_Last_RX, bus.o_Sent_Cnt};
    tests_run++;
    if (flags !== 9'b1_0_0000_0_0_0) begin tests_failed++; $display("FAIL reset_flags: got %b expected 100000000", flags); end
    tests_run++;
    if (data !== 24'h000000) begin tests_failed++; $display("FAIL reset_data: got %h expected 000000", data); end
    rst_l = 1'b1;
  endtask

  task automatic test_latency;
    @(negedge clk); bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'h61;
    @(negedge clk); bus.i_Wr_DV = 1'b0;
    tests_run++;
    if (bus.o_Count !== 4'd1 || bus.o_TX_DV !== 1'b0) begin tests_failed++; $display("FAIL lat_stored: count %0d dv %b expected 1 0", bus.o_Count, bus.o_TX_DV); end
    @(negedge clk);
    tests_run++;
    if ({bus.o_TX_DV, bus.o_TX_Byte, bus.o_Sent_Cnt, bus.o_Empty} !== {1'b1, 8'h61, 8'd1, 1'b1}) begin
      tests_failed++; $display("FAIL lat_issue: dv %b byte %h sent %0d empty %b expected 1 61 1 1", bus.o_TX_DV, bus.o_TX_Byte, bus.o_Sent_Cnt, bus.o_Empty);
    end
    @(negedge clk);
    tests_run++;
    if (bus.o_TX_DV !== 1'b0 || bus.o_TX_Byte !== 8'h61) begin tests_failed++; $display("FAIL lat_pulse: dv %b byte %h expected 0 61", bus.o_TX_DV, bus.o_TX_Byte); end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.o_Busy !== 1'b0) begin tests_failed++; $display("FAIL lat_idle: busy %b expected 0", bus.o_Busy); end
  endtask

  task automatic test_back_to_back;
    int k = 0, last_dv = 0, low = 0;
    bit done_ready = 0, busy_drop = 0, finished = 0;
    bus.i_TX_Ready = 1'b1;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      if (done_ready) begin
        tests_run++;
        if (bus.o_Busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_busy_end: busy %b expected 0", bus.o_Busy); end
        finished = 1;
      end else begin
        if (k > 0 && bus.o_Busy !== 1'b1) busy_drop = 1;
        if (bus.o_TX_DV === 1'b1) begin
          tests_run++;
          if (bus.o_TX_Byte !== 8'h61 + k[7:0]) begin tests_failed++; $display("FAIL b2b_byte%0d: got %h expected %h", k, bus.o_TX_Byte, 8'h61 + k[7:0]); end
          if (k > 0) begin
            tests_run++;
            if (cyc - last_dv < 22) begin tests_failed++; $display("FAIL b2b_gap%0d: got %0d expected >=22", k, cyc - last_dv); end
          end
          last_dv = cyc;
          k++;
          bus.i_TX_Ready = 1'b0;
          low = 20;
        end else if (low > 0) begin
          low--;
          if (low == 0) begin
            bus.i_TX_Ready = 1'b1;
            if (k == 5) done_ready = 1;
          end
        end
        bus.i_Wr_DV   = (cyc < 5);
        bus.i_Wr_Byte = 8'h61 + cyc[7:0];
      end
    end
    bus.i_Wr_DV = 1'b0;
    tests_run++;
    if (k !== 5 || !finished) begin tests_failed++; $display("FAIL b2b_count: got %0d pulses finished %b expected 5 1", k, finished); end
    tests_run++;
    if (busy_drop) begin tests_failed++; $display("FAIL b2b_busy_early: busy fell %b expected 0", busy_drop); end
  endtask

  task automatic test_overflow;
    int n = 0;
    bus.i_TX_Ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'h10 + i[7:0];
    end
    @(negedge clk); bus.i_Wr_DV = 1'b0;
    tests_run++;
    if ({bus.o_Full, bus.o_Count, bus.o_Overflow, bus.o_Empty} !== {1'b1, 4'd8, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL ovf_state: full %b count %0d ovf %b empty %b expected 1 8 1 0", bus.o_Full, bus.o_Count, bus.o_Overflow, bus.o_Empty);
    end
    bus.i_TX_Ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.o_TX_DV === 1'b1) begin
        tests_run++;
        if (bus.o_TX_Byte !== 8'h10 + n[7:0]) begin tests_failed++; $display("FAIL ovf_drain%0d: got %h expected %h", n, bus.o_TX_Byte, 8'h10 + n[7:0]); end
        n++;
      end
    end
    tests_run++;
    if (n !== 8) begin tests_failed++; $display("FAIL ovf_drain_count: got %0d expected 8", n); end
    tests_run++;
    if (bus.o_Overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b expected 1", bus.o_Overflow); end
  endtask

  task automatic test_flush;
    bit dv_seen = 0;
    bus.i_TX_Ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'h20 + i[7:0];
    end
    @(negedge clk); bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'h99; bus.i_Flush = 1'b1;
    tests_run++;
    if (bus.o_Full !== 1'b1 || bus.o_Count !== 4'd8) begin tests_failed++; $display("FAIL flush_pre: full %b count %0d expected 1 8", bus.o_Full, bus.o_Count); end
    @(negedge clk); bus.i_Wr_DV = 1'b0; bus.i_Flush = 1'b0;
    tests_run++;
    if ({bus.o_Count, bus.o_Empty, bus.o_Full, bus.o_Overflow} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL flush_state: count %0d empty %b full %b ovf %b expected 0 1 0 0", bus.o_Count, bus.o_Empty, bus.o_Full, bus.o_Overflow);
    end
    bus.i_TX_Ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.o_TX_DV === 1'b1) dv_seen = 1;
    end
    tests_run++;
    if (dv_seen || bus.o_Busy !== 1'b0) begin tests_failed++; $display("FAIL flush_quiet: dv_seen %b busy %b expected 0 0", dv_seen, bus.o_Busy); end
  endtask

  task automatic test_rx;
    bus.i_TX_Ready = 1'b1;
    @(negedge clk); bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'h42;
    @(negedge clk); bus.i_Wr_DV = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.o_TX_DV !== 1'b1 || bus.o_TX_Byte !== 8'h42) begin tests_failed++; $display("FAIL rx_issue: dv %b byte %h expected 1 42", bus.o_TX_DV, bus.o_TX_Byte); end
    bus.i_TX_Ready = 1'b0;
    @(negedge clk); bus.i_RX_DV = 1'b1; bus.i_RX_Byte = 8'hA5;
    @(negedge clk);
    tests_run++;
    if (bus.o_Last_RX !== 8'hA5 || bus.o_Busy !== 1'b1) begin tests_failed++; $display("FAIL rx_first: last %h busy %b expected a5 1", bus.o_Last_RX, bus.o_Busy); end
    bus.i_RX_Byte = 8'h3C;
    @(negedge clk); bus.i_RX_DV = 1'b0;
    tests_run++;
    if (bus.o_Last_RX !== 8'h3C) begin tests_failed++; $display("FAIL rx_second: got %h expected 3c", bus.o_Last_RX); end
    bus.i_TX_Ready = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.o_Busy !== 1'b0 || bus.o_Last_RX !== 8'h3C) begin tests_failed++; $display("FAIL rx_done: busy %b last %h expected 0 3c", bus.o_Busy, bus.o_Last_RX); end
  endtask

  task automatic test_wrap_reset;
    bit bad_byte = 0, timeout = 0, got;
    logic [8:0]  flags;
    logic [23:0] data;
    rst_l = 1'b0;
    @(negedge clk); @(negedge clk); rst_l = 1'b1;
    bus.i_TX_Ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      @(negedge clk); bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = (i == 256) ? 8'h77 : i[7:0];
      @(negedge clk); bus.i_Wr_DV = 1'b0;
      got = 0;
      for (int j = 0; j < 10 && !got; j++) begin
        @(negedge clk);
        if (bus.o_TX_DV === 1'b1) begin
          got = 1;
          if (i < 256 && bus.o_TX_Byte !== i[7:0]) bad_byte = 1;
        end
      end
      if (!got) timeout = 1;
      if (i == 254) begin
        tests_run++;
        if (bus.o_Sent_Cnt !== 8'd255) begin tests_failed++; $display("FAIL wrap_255: got %0d expected 255", bus.o_Sent_Cnt); end
      end
      if (i == 255) begin
        tests_run++;
        if (bus.o_Sent_Cnt !== 8'd0) begin tests_failed++; $display("FAIL wrap_zero: got %0d expected 0", bus.o_Sent_Cnt); end
      end
    end
    tests_run++;
    if (bad_byte || timeout) begin tests_failed++; $display("FAIL wrap_stream: bad_byte %b timeout %b expected 0 0", bad_byte, timeout); end
    bus.i_TX_Ready = 1'b0;
    @(negedge clk); bus.i_Wr_DV = 1'b1; bus.i_Wr_Byte = 8'h78; bus.i_RX_DV = 1'b1; bus.i_RX_Byte = 8'h5A;
    @(negedge clk); bus.i_Wr_Byte = 8'h79; bus.i_RX_DV = 1'b0;
    @(negedge clk); bus.i_Wr_DV = 1'b0;
    tests_run++;
    if ({bus.o_Count, bus.o_Busy, bus.o_Last_RX, bus.o_Sent_Cnt, bus.o_TX_Byte} !== {4'd2, 1'b1, 8'h5A, 8'd1, 8'h77}) begin
      tests_failed++; $display("FAIL pre_reset: count %0d busy %b last %h sent %0d byte %h expected 2 1 5a 1 77",
                               bus.o_Count, bus.o_Busy, bus.o_Last_RX, bus.o_Sent_Cnt, bus.o_TX_Byte);
    end
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    flags = {bus.o_Empty, bus.o_Full, bus.o_Count, bus.o_Overflow, bus.o_TX_DV, bus.o_Busy};
    data  = {bus.o_TX_Byte, bus.o_Last_RX, bus.o_Sent_Cnt};
    tests_run++;
    if (flags !== 9'b1_0_0000_0_0_0) begin tests_failed++; $display("FAIL midwait_reset_flags: got %b expected 100000000", flags); end
    tests_run++;
    if (data !== 24'h000000) begin tests_failed++; $display("FAIL midwait_reset_data: got %h expected 000000", data); end
  endtask

  initial begin
    rst_l = 1'b0;
    bus.i_TX_Ready = 1'b1;
    idle_inputs();
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_rx();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
